// File: rtl/fetch_unit_pkg.sv
// Shared ISA constants for the fetch path: NOP encoding, branch target field, fetch defaults.
// Pure constants; no logic, no latency, no flow control.
package fetch_unit_pkg;

    localparam int              INSTR_W          = 14;
    localparam logic [13:0]     NOP              = 14'h0000;

    // goto/call carry an 11-bit page offset; the upper bits come from PCLATH
    localparam int              TGT_MSB          = 10;
    localparam int              TGT_LSB          = 0;

    localparam int              DEF_STACK_DEPTH  = 8;
    localparam int              DEF_RESET_VECTOR = 0;

endpackage

// File: rtl/fetch_unit_return_stack.sv
// Circular hardware return stack with saturating fill count and sticky over/underflow flags.
// Push/pop take effect on the next edge, pop_data is combinational; no backpressure, overflow overwrites oldest.
module return_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] pop_data,
    output logic         overflow,
    output logic         underflow
);
    localparam int             PW       = $clog2(DEPTH);
    localparam int             CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    // Contents are deliberately left unreset; only the bookkeeping is.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[ptr_q] <= push_data;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (push) begin
            ptr_d = ptr_q + PTR_ONE;
            if (cnt_q == CNT_FULL) ovf_d = 1'b1;
            else                   cnt_d = cnt_q + CNT_ONE;
        end else if (pop) begin
            ptr_d = ptr_q - PTR_ONE;
            if (cnt_q == '0) unf_d = 1'b1;
            else             cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign pop_data  = mem_q[ptr_q - PTR_ONE];
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: rtl/fetch_unit.sv
// Program counter, instruction register and return stack feeding the instruction decoder.
// prog_addr is the live PC (zero latency); IR/PC update one edge after a strobe; no backpressure.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH     = 13,
    parameter int STACK_DEPTH  = DEF_STACK_DEPTH,
    parameter int RESET_VECTOR = DEF_RESET_VECTOR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_rd_en,
    input  logic                 instr_flush,
    input  logic                 pc_incr_en,
    input  logic                 pc_j_en,
    input  logic                 pc_call_en,
    input  logic                 pc_ret_en,
    input  logic [PC_WIDTH-9:0]  pclath,
    input  logic [INSTR_W-1:0]   prog_data,
    output logic [PC_WIDTH-1:0]  prog_addr,
    output logic [INSTR_W-1:0]   instr_current,
    output logic                 stk_overflow,
    output logic                 stk_underflow
);
    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_VECTOR);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [PC_WIDTH-1:0] jump_tgt;
    logic [PC_WIDTH-1:0] stk_top;
    logic                stk_push, stk_pop;
    logic                unused_pclath;

    // Low PCLATH bits only matter for computed jumps, which are handled elsewhere.
    assign unused_pclath = ^pclath[2:0];
    assign jump_tgt      = {pclath[PC_WIDTH-9:3], ir_q[TGT_MSB:TGT_LSB]};

    // A jump shadows any simultaneous return, so push and pop are mutually exclusive.
    assign stk_push = pc_j_en & pc_call_en;
    assign stk_pop  = pc_ret_en & ~pc_j_en;

    always_comb begin
        pc_d = pc_q;
        if (pc_j_en)         pc_d = jump_tgt;
        else if (pc_ret_en)  pc_d = stk_top;
        else if (pc_incr_en) pc_d = pc_q + PC_ONE;
    end

    always_comb begin
        ir_d = ir_q;
        if (instr_flush)      ir_d = NOP;
        else if (instr_rd_en) ir_d = prog_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PC_RST;
            ir_q <= NOP;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_WIDTH)
    ) u_return_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_q),
        .pop_data  (stk_top),
        .overflow  (stk_overflow),
        .underflow (stk_underflow)
    );

    assign prog_addr     = pc_q;
    assign instr_current = ir_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of strobe vectors plus hand sequences for stack and reset corners.
module tb_fetch_unit;

    localparam logic [5:0] S_IDLE = 6'b000000;
    localparam logic [5:0] S_RD   = 6'b100000;
    localparam logic [5:0] S_FL   = 6'b010000;
    localparam logic [5:0] S_INC  = 6'b001000;
    localparam logic [5:0] S_J    = 6'b000100;
    localparam logic [5:0] S_CALL = 6'b000010;
    localparam logic [5:0] S_RET  = 6'b000001;

    typedef struct packed {
        logic [12:0] pc;
        logic [13:0] ir;
        logic        ov;
        logic        un;
    } obs_t;

    typedef struct {
        logic [5:0]  s;
        logic [4:0]  pl;
        obs_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_rd_en, instr_flush, pc_incr_en, pc_j_en, pc_call_en, pc_ret_en;
    logic [4:0]  pclath;
    logic [13:0] prog_data;
    logic [12:0] prog_addr;
    logic [13:0] instr_current;
    logic        stk_overflow, stk_underflow;

    logic [13:0] rom [0:8191];
    obs_t        sb_q [$];
    logic [12:0] model_stk [$];
    vec_t        tbl [20];
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;
    assign prog_data = rom[prog_addr];

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_rd_en   (instr_rd_en),
        .instr_flush   (instr_flush),
        .pc_incr_en    (pc_incr_en),
        .pc_j_en       (pc_j_en),
        .pc_call_en    (pc_call_en),
        .pc_ret_en     (pc_ret_en),
        .pclath        (pclath),
        .prog_data     (prog_data),
        .prog_addr     (prog_addr),
        .instr_current (instr_current),
        .stk_overflow  (stk_overflow),
        .stk_underflow (stk_underflow)
    );

    task automatic expect_obs(input logic [12:0] pc, input logic [13:0] ir, input logic ov, input logic un);
        obs_t e;
        e.pc = pc; e.ir = ir; e.ov = ov; e.un = un;
        sb_q.push_back(e);
    endtask

    task automatic check(input string name);
        obs_t e, a;
        a.pc = prog_addr; a.ir = instr_current; a.ov = stk_overflow; a.un = stk_underflow;
        n_total++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got pc=%h ir=%h ov=%b un=%b", name, a.pc, a.ir, a.ov, a.un);
        end else begin
            e = sb_q.pop_front();
            if (a === e) n_pass++;
            else $display("FAIL %s: got pc=%h ir=%h ov=%b un=%b, want pc=%h ir=%h ov=%b un=%b",
                          name, a.pc, a.ir, a.ov, a.un, e.pc, e.ir, e.ov, e.un);
        end
    endtask

    task automatic step(input string name, input logic [5:0] s, input logic [4:0] pl,
                        input logic [12:0] pc, input logic [13:0] ir, input logic ov, input logic un);
        {instr_rd_en, instr_flush, pc_incr_en, pc_j_en, pc_call_en, pc_ret_en} = s;
        pclath = pl;
        expect_obs(pc, ir, ov, un);
        @(posedge clk);
        #1;
        {instr_rd_en, instr_flush, pc_incr_en, pc_j_en, pc_call_en, pc_ret_en} = S_IDLE;
        check(name);
    endtask

    function automatic vec_t mk(input logic [5:0] s, input logic [4:0] pl, input logic [12:0] pc,
                                input logic [13:0] ir);
        vec_t v;
        v.s = s; v.pl = pl; v.exp.pc = pc; v.exp.ir = ir; v.exp.ov = 1'b0; v.exp.un = 1'b0;
        return v;
    endfunction

    initial begin
        logic [12:0] cur;
        logic        ov;
        logic [13:0] fetch_words [3];

        for (int i = 0; i < 8192; i++) rom[i] = 14'h0000;
        rom[0] = 14'h3055; rom[1] = 14'h0080; rom[2] = 14'h0000; rom[3] = 14'h2ABC;
        rom[13'h1ABC] = 14'h2010;
        rom[13'h0010] = 14'h2200;
        rom[13'h0207] = 14'h2123;
        rom[13'h0208] = 14'h2FFF;
        fetch_words[0] = 14'h3055; fetch_words[1] = 14'h0080; fetch_words[2] = 14'h0000;

        for (int k = 0; k < 3; k++) begin
            tbl[4*k] = mk(S_RD | S_INC, 5'd0, 13'(k + 1), fetch_words[k]);
            for (int j = 1; j < 4; j++) tbl[4*k+j] = mk(S_IDLE, 5'd0, 13'(k + 1), fetch_words[k]);
        end
        tbl[12] = mk(S_RD | S_INC,  5'd0,      13'h0004, 14'h2ABC);
        tbl[13] = mk(S_FL | S_J,    5'b11000,  13'h1ABC, 14'h0000);
        tbl[14] = mk(S_RD,          5'd0,      13'h1ABC, 14'h2010);
        tbl[15] = mk(S_J,           5'd0,      13'h0010, 14'h2010);
        tbl[16] = mk(S_RD,          5'd0,      13'h0010, 14'h2200);
        tbl[17] = mk(S_CALL,        5'd0,      13'h0010, 14'h2200);
        tbl[18] = mk(S_J | S_CALL,  5'd0,      13'h0200, 14'h2200);
        tbl[19] = mk(S_RET,         5'd0,      13'h0010, 14'h2200);

        rst_n = 1'b0;
        {instr_rd_en, instr_flush, pc_incr_en, pc_j_en, pc_call_en, pc_ret_en} = S_IDLE;
        pclath = 5'd0;
        #3;
        expect_obs(13'h0000, 14'h0000, 1'b0, 1'b0);
        check("reset_initial");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].s, tbl[i].pl, tbl[i].exp.pc, tbl[i].exp.ir,
                              tbl[i].exp.ov, tbl[i].exp.un);

        // Nine calls from distinct return addresses, then unwind past empty.
        cur = 13'h0010;
        ov  = 1'b0;
        for (int i = 0; i < 9; i++) begin
            model_stk.push_back(cur);
            if (model_stk.size() > 8) begin
                void'(model_stk.pop_front());
                ov = 1'b1;
            end
            step($sformatf("call%0d", i), S_J | S_CALL, 5'd0, 13'h0200, 14'h2200, ov, 1'b0);
            cur = 13'h0200;
            for (int k = 0; k <= i; k++) begin
                cur = cur + 13'd1;
                step("call_incr", S_INC, 5'd0, cur, 14'h2200, ov, 1'b0);
            end
        end
        for (int i = 0; i < 8; i++) begin
            cur = model_stk.pop_back();
            step($sformatf("ret%0d", i), S_RET, 5'd0, cur, 14'h2200, 1'b1, 1'b0);
        end
        step("ret_underflow", S_RET, 5'd0, 13'h0208, 14'h2200, 1'b1, 1'b1);

        step("load_far",      S_RD,               5'd0,     13'h0208, 14'h2FFF, 1'b1, 1'b1);
        step("jump_top",      S_J,                5'b11000, 13'h1FFF, 14'h2FFF, 1'b1, 1'b1);
        step("pc_wrap",       S_INC,              5'd0,     13'h0000, 14'h2FFF, 1'b1, 1'b1);
        step("skip",          S_FL | S_RD | S_INC, 5'd0,    13'h0001, 14'h0000, 1'b1, 1'b1);
        step("jump_over_ret", S_J | S_RET,        5'd0,     13'h0000, 14'h0000, 1'b1, 1'b1);
        step("ptr_unchanged", S_RET,              5'd0,     13'h0207, 14'h0000, 1'b1, 1'b1);
        step("load_0123",     S_RD,               5'd0,     13'h0207, 14'h2123, 1'b1, 1'b1);
        step("jump_0123",     S_J,                5'd0,     13'h0123, 14'h2123, 1'b1, 1'b1);

        #2;
        rst_n = 1'b0;
        #1;
        expect_obs(13'h0000, 14'h0000, 1'b0, 1'b0);
        check("reset_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_reset_hold", S_IDLE, 5'd0, 13'h0000, 14'h0000, 1'b0, 1'b0);
        step("post_reset_fetch", S_RD | S_INC, 5'd0, 13'h0001, 14'h3055, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program counter, instruction register and hardware return stack. Sits directly upstream of instruction_decoder.
- Presents the program-memory address, latches the fetched word into instr_current, and acts on the decoder's control strobes: instr_rd_en, instr_flush, pc_incr_en, pc_j_en, plus call/return.
- Program memory is an external asynchronous-read ROM.

Parameters:
- PC_WIDTH, 13, program counter width in bits; minimum 12.
- STACK_DEPTH, 8, return stack entries; must be a power of 2.
- RESET_VECTOR, 0, PC value after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_rd_en  in  1  load prog_data into instr_current.
- instr_flush  in  1  load NOP into instr_current; overrides instr_rd_en.
- pc_incr_en  in  1  pc <= pc+1.
- pc_j_en  in  1  pc <= jump target.
- pc_call_en  in  1  qualifier with pc_j_en: push pc before the jump.
- pc_ret_en  in  1  pc <= popped stack entry.
- pclath  in  PC_WIDTH-8  PCLATH register value.
- prog_data  in  14  ROM word at prog_addr, combinational.
- prog_addr  out  PC_WIDTH  equals pc.
- instr_current  out  14  instruction register, to decoder.
- stk_overflow  out  1  sticky: a push occurred while the stack was full.
- stk_underflow  out  1  sticky: a pop occurred while the stack was empty.

Behaviour:
- Reset (async assert, sync release): pc=RESET_VECTOR, instr_current=14'h0000 (NOP), stack pointer=0, fill count=0, both sticky flags=0. Stack contents are not reset.
- prog_addr = pc, combinational, no added latency.
- Jump target = {pclath[PC_WIDTH-9:3], instr_current[10:0]}. For PC_WIDTH=13 this is {pclath[4:3], instr_current[10:0]}.
- PC next-state priority (highest first):
  - pc_j_en: pc <= target. If pc_call_en is also high, push the current pc (the already-incremented return address) in the same edge.
  - pc_ret_en: pc <= top of stack; pop.
  - pc_incr_en: pc <= pc+1, wrapping modulo 2^PC_WIDTH.
  - none: hold.
- pc_call_en without pc_j_en: ignored. pc_ret_en together with pc_j_en: return ignored, no pop.
- Instruction register priority:
  - instr_flush: instr_current <= 14'h0000.
  - else instr_rd_en: instr_current <= prog_data (the word at the pre-update pc).
  - else hold.
- Combined strobes and resulting sequences:
  - rd_en+incr_en: normal fetch; IR gets word at old pc, pc advances.
  - flush+j_en: 2-slot branch; the NOP executes, then the target is fetched.
  - flush+incr_en: skip; the next word is discarded.
- Stack: circular array of STACK_DEPTH x PC_WIDTH, pointer ptr of width log2(STACK_DEPTH).
  - Push: mem[ptr] <= pc; ptr <= ptr+1 (wraps). Fill count saturates at STACK_DEPTH. If count==STACK_DEPTH before the push, set stk_overflow and overwrite the oldest entry.
  - Pop: pc <= mem[ptr-1]; ptr <= ptr-1 (wraps). Count saturates at 0. If count==0 before the pop, set stk_underflow; the pop still wraps and returns stale data.
- Sticky flags clear only on reset.
- No push and pop in the same cycle; the priority rules above make that impossible.

Decomposition:
- Shared package (extends isa.vh):
  - NOP encoding 14'h0000.
  - goto/call target field slice [10:0].
  - Default STACK_DEPTH and RESET_VECTOR.
- One sub-module, return_stack:
  - Owns memory, pointer, fill count and the sticky flags.
  - Ports: clk, rst_n, push, pop, push_data, pop_data, overflow, underflow.

Test Plan:
- Reset: rst_n low mid-run with pc=0x0123 -> pc, prog_addr=0, instr_current=0, flags=0 immediately, without a clock edge.
- Fetch: ROM[0..2]={0x3055,0x0080,0x0000}; rd_en+incr_en pulse every 4th cycle -> instr_current = 0x3055, then 0x0080, then 0x0000; pc = 1, 2, 3.
- Goto/flush: instr_current=0x2ABC (goto 0x2BC), pclath=5'b11000, flush+j_en -> pc=0x1ABC, instr_current=0x0000; next rd_en loads ROM[0x1ABC].
- Call/return: pc=0x0010, call to 0x0200 (j_en+call_en) -> pc=0x0200, top=0x0010; ret_en -> pc=0x0010, count back to 0.
- Overflow/underflow: 9 calls -> stk_overflow=1, 8 returns yield the last 8 return addresses; a 9th return -> stk_underflow=1.
- Wrap/skip/priority:
  - pc=0x1FFF, incr_en -> pc=0x0000.
  - flush+incr_en -> instr_current=0, pc+1.
  - j_en+ret_en together -> jump taken, stack pointer unchanged.
